playlist_mcu: RTL
=================

Name: playlist_mcu

Overview:
Parametrised music-player control unit for a playlist of NUM_SONGS songs, which need not be a power of two.
- Sequences play, pause, next, previous and reverse commands and a repeat mode (OFF / ONE / ALL).
- Drives song select, play enable, direction and a one-cycle player-restart pulse to the song_reader/note_player chain.
- Reacts to song_done from the player. Sits between the button press detectors and the song player.

Parameters:
NUM_SONGS, 4, number of songs in ROM; legal range 2..256.
SONG_W, $clog2(NUM_SONGS), width of song index; must satisfy 2^SONG_W >= NUM_SONGS.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
play_button  input  1  one-cycle pulse: toggle play/pause
next_button  input  1  one-cycle pulse: next song
prev_button  input  1  one-cycle pulse: previous song
reverse_button  input  1  one-cycle pulse: toggle playback direction
mode_button  input  1  one-cycle pulse: cycle repeat mode
song_done  input  1  one-cycle pulse from player: current song finished
play  output  1  1 = player advancing
reset_player  output  1  one-cycle restart pulse to player
song  output  SONG_W  current song index, 0..NUM_SONGS-1
backwards  output  1  1 = play current song end-to-start
repeat_mode  output  2  0 = OFF, 1 = ONE, 2 = ALL; value 3 never produced
at_end  output  1  1 = playlist finished (DONE state)

Behaviour:
- Reset and timing:
  - All outputs are registered.
  - Asynchronous reset forces: song=0, play=0, backwards=0, repeat_mode=0, at_end=0, reset_player=1, state STOPPED.
  - First clock edge after reset release clears reset_player.
  - Every input is sampled on the rising edge; the response is visible after that edge (1-cycle latency).
- States: STOPPED (play=0), PLAYING (play=1), PAUSED (play=0), DONE (play=0, at_end=1).
- Priority when several inputs are high in the same cycle: play > next > prev > reverse > mode > song_done. Only the highest-priority input acts; the others are dropped.
- play_button:
  - STOPPED/PAUSED -> PLAYING.
  - PLAYING -> PAUSED.
  - DONE -> PLAYING with song=0, backwards=0, at_end=0, reset_player pulse.
- next_button: song = (song==NUM_SONGS-1) ? 0 : song+1; backwards=0; reset_player pulse.
  - PLAYING stays PLAYING.
  - PAUSED goes to STOPPED.
  - DONE goes to STOPPED with at_end=0.
- prev_button: song = (song==0) ? NUM_SONGS-1 : song-1; otherwise identical to next_button.
- reverse_button: backwards toggles; reset_player pulse; state unchanged, except DONE goes to STOPPED.
- mode_button: repeat_mode cycles 0 -> 1 -> 2 -> 0. No reset_player pulse, no state change.
- song_done is acted on only in PLAYING; it is ignored in every other state.
  - ONE: song unchanged, backwards unchanged, reset_player pulse, stay PLAYING.
  - ALL: advance with wrap, backwards=0, reset_player pulse, stay PLAYING.
  - OFF with song<NUM_SONGS-1: advance, backwards=0, reset_player pulse, stay PLAYING.
  - OFF with song==NUM_SONGS-1: song=0, backwards=0, reset_player pulse, go to DONE.
- reset_player is exactly one cycle wide per triggering event. Back-to-back triggers produce back-to-back pulses.
- Reset asserted mid-operation overrides everything asynchronously. A pending restart is replaced by the reset pulse.

Optional Feature:
SHUFFLE_EN defined:
- Adds input shuffle_button (one-cycle pulse, priority just below mode_button) and output shuffle (reset 0); shuffle_button toggles shuffle.
- Adds an 8-bit maximal LFSR, x^8+x^6+x^5+x^4+1, seeded 8'h01 on reset, stepping every cycle.
- With shuffle=1, next_button and song_done in ALL/OFF select a random index:
  - cand = lfsr[SONG_W-1:0]; subtract NUM_SONGS once if cand >= NUM_SONGS.
  - If cand == song, use the wrapped increment instead.
  - prev_button is unaffected.
- In OFF with shuffle=1, a played-count register (reset 0, cleared on any manual song change) counts song_done events. DONE is entered when the count reaches NUM_SONGS.
SHUFFLE_EN undefined: no shuffle port, no shuffle output, no LFSR; behaviour exactly as above.

Test Plan:
- Reset released, NUM_SONGS=5 -> song=0, play=0, repeat_mode=0, reset_player=1 for exactly one cycle.
- play, then 5x next at NUM_SONGS=5 -> song 1,2,3,4,0; play stays 1; five reset_player pulses.
- song=0, prev -> song=4; play and next asserted in the same cycle -> only play toggles, song unchanged.
- repeat OFF, playing song 4 of 5, song_done -> song=0, play=0, at_end=1; then play -> play=1, at_end=0, reset_player pulse.
- repeat ONE, backwards=1, song=2, song_done -> song=2, backwards=1, reset_player pulse; song_done while PAUSED -> no change.
- Reset asserted mid-song while PLAYING, song=3, repeat ALL -> all outputs immediately return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/playlist_mcu_if.sv
// Control bus between the button/player side and playlist_mcu.
// SHUFFLE_EN adds the shuffle button and shuffle status lines.
interface playlist_mcu_if #(
  parameter int SONG_W = 2
);
  logic              play_button;
  logic              next_button;
  logic              prev_button;
  logic              reverse_button;
  logic              mode_button;
  logic              song_done;
  logic              play;
  logic              reset_player;
  logic [SONG_W-1:0] song;
  logic              backwards;
  logic [1:0]        repeat_mode;
  logic              at_end;
`ifdef SHUFFLE_EN
  logic              shuffle_button;
  logic              shuffle;
`endif

  modport master (
`ifdef SHUFFLE_EN
    output shuffle_button,
    input  shuffle,
`endif
    output play_button, next_button, prev_button, reverse_button, mode_button, song_done,
    input  play, reset_player, song, backwards, repeat_mode, at_end
  );

  modport slave (
`ifdef SHUFFLE_EN
    input  shuffle_button,
    output shuffle,
`endif
    input  play_button, next_button, prev_button, reverse_button, mode_button, song_done,
    output play, reset_player, song, backwards, repeat_mode, at_end
  );
endinterface

// File: rtl/playlist_mcu.sv
// Playlist sequencer: play/pause/next/prev/reverse/repeat-mode control of the song player.
// Optional SHUFFLE_EN macro adds random song selection driven by an 8-bit LFSR.
module playlist_mcu #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic           clk,
  input  logic           reset,
  playlist_mcu_if.slave  bus
);

  typedef enum logic [1:0] {ST_STOPPED, ST_PLAYING, ST_PAUSED, ST_DONE} state_t;
  typedef enum logic [1:0] {MODE_OFF = 2'd0, MODE_ONE = 2'd1, MODE_ALL = 2'd2} mode_t;

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  state_t            r_state, w_state;
  mode_t             r_mode, w_mode;
  logic [SONG_W-1:0] r_song, w_song, w_adv;
  logic              r_back, w_back;
  logic              r_rp, w_rp;
  logic              r_play, r_at_end;

  function automatic logic [SONG_W-1:0] song_inc(input logic [SONG_W-1:0] s);
    return (s == LAST_SONG) ? {SONG_W{1'b0}} : s + SONG_W'(1);
  endfunction

  function automatic logic [SONG_W-1:0] song_dec(input logic [SONG_W-1:0] s);
    return (s == {SONG_W{1'b0}}) ? LAST_SONG : s - SONG_W'(1);
  endfunction

`ifdef SHUFFLE_EN
  logic              r_shuffle, w_shuffle;
  logic [7:0]        r_lfsr;
  logic [SONG_W:0]   r_cnt, w_cnt;
  logic [SONG_W-1:0] w_cand_raw, w_cand, w_rand;

  // Fold the LFSR sample into range, never repeating the current song.
  always_comb begin
    w_cand_raw = r_lfsr[SONG_W-1:0];
    if ({1'b0, w_cand_raw} >= (SONG_W+1)'(NUM_SONGS)) begin
      w_cand = w_cand_raw - SONG_W'(NUM_SONGS);
    end else begin
      w_cand = w_cand_raw;
    end
    w_rand = (w_cand == r_song) ? song_inc(r_song) : w_cand;
  end

  assign w_adv = r_shuffle ? w_rand : song_inc(r_song);
`else
  assign w_adv = song_inc(r_song);
`endif

  // Next-state and next-output decode; only the highest-priority input acts.
  always_comb begin
    w_state = r_state;
    w_mode  = r_mode;
    w_song  = r_song;
    w_back  = r_back;
    w_rp    = 1'b0;
`ifdef SHUFFLE_EN
    w_shuffle = r_shuffle;
    w_cnt     = r_cnt;
`endif
    if (bus.play_button) begin
      case (r_state)
        ST_PLAYING: w_state = ST_PAUSED;
        ST_DONE: begin
          w_state = ST_PLAYING;
          w_song  = {SONG_W{1'b0}};
          w_back  = 1'b0;
          w_rp    = 1'b1;
`ifdef SHUFFLE_EN
          w_cnt   = '0;
`endif
        end
        default: w_state = ST_PLAYING;
      endcase
    end else if (bus.next_button || bus.prev_button) begin
      w_song = bus.next_button ? w_adv : song_dec(r_song);
      w_back = 1'b0;
      w_rp   = 1'b1;
`ifdef SHUFFLE_EN
      w_cnt  = '0;
`endif
      case (r_state)
        ST_PAUSED, ST_DONE: w_state = ST_STOPPED;
        default:            w_state = r_state;
      endcase
    end else if (bus.reverse_button) begin
      w_back = ~r_back;
      w_rp   = 1'b1;
      if (r_state == ST_DONE) begin
        w_state = ST_STOPPED;
      end else begin
        w_state = r_state;
      end
    end else if (bus.mode_button) begin
      case (r_mode)
        MODE_OFF: w_mode = MODE_ONE;
        MODE_ONE: w_mode = MODE_ALL;
        default:  w_mode = MODE_OFF;
      endcase
`ifdef SHUFFLE_EN
    end else if (bus.shuffle_button) begin
      w_shuffle = ~r_shuffle;
`endif
    end else if (bus.song_done && (r_state == ST_PLAYING)) begin
      w_rp = 1'b1;
      case (r_mode)
        MODE_ONE: w_song = r_song;
        MODE_ALL: begin
          w_song = w_adv;
          w_back = 1'b0;
        end
        default: begin
          w_back = 1'b0;
`ifdef SHUFFLE_EN
          if (r_shuffle) begin
            w_cnt = r_cnt + (SONG_W+1)'(1);
            if (w_cnt == (SONG_W+1)'(NUM_SONGS)) begin
              w_cnt   = '0;
              w_song  = {SONG_W{1'b0}};
              w_state = ST_DONE;
            end else begin
              w_song  = w_adv;
            end
          end else
`endif
          if (r_song == LAST_SONG) begin
            w_song  = {SONG_W{1'b0}};
            w_state = ST_DONE;
          end else begin
            w_song  = w_adv;
          end
        end
      endcase
    end else begin
      w_state = r_state;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_STOPPED;
      r_mode   <= MODE_OFF;
      r_song   <= {SONG_W{1'b0}};
      r_back   <= 1'b0;
      r_rp     <= 1'b1;
      r_play   <= 1'b0;
      r_at_end <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_mode   <= w_mode;
      r_song   <= w_song;
      r_back   <= w_back;
      r_rp     <= w_rp;
      r_play   <= (w_state == ST_PLAYING);
      r_at_end <= (w_state == ST_DONE);
    end
  end

`ifdef SHUFFLE_EN
  // Shuffle flag, played counter and free-running LFSR (x^8+x^6+x^5+x^4+1).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shuffle <= 1'b0;
      r_cnt     <= '0;
      r_lfsr    <= 8'h01;
    end else begin
      r_shuffle <= w_shuffle;
      r_cnt     <= w_cnt;
      r_lfsr    <= {r_lfsr[6:0], ^(r_lfsr & 8'b1011_1000)};
    end
  end

  assign bus.shuffle = r_shuffle;
`endif

  assign bus.play         = r_play;
  assign bus.reset_player = r_rp;
  assign bus.song         = r_song;
  assign bus.backwards    = r_back;
  assign bus.repeat_mode  = r_mode;
  assign bus.at_end       = r_at_end;

endmodule
